// File: rtl/composite_bus_slice_if.sv
// Five-channel composite bus bundle (one side of the link).
// The master drives addr_read, addr_write and data_write. It receives
// data_read and resp_write. The slave modport mirrors those directions.
interface composite_bus_slice_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] addr_read_bus_data;
    logic                  addr_read_bus_valid;
    logic                  addr_read_bus_ready;
    logic [DATA_WIDTH-1:0] addr_write_bus_data;
    logic                  addr_write_bus_valid;
    logic                  addr_write_bus_ready;
    logic [DATA_WIDTH-1:0] data_write_bus_data;
    logic                  data_write_bus_valid;
    logic                  data_write_bus_ready;
    logic [DATA_WIDTH-1:0] data_read_bus_data;
    logic                  data_read_bus_valid;
    logic                  data_read_bus_ready;
    logic [DATA_WIDTH-1:0] resp_write_bus_data;
    logic                  resp_write_bus_valid;
    logic                  resp_write_bus_ready;

    modport master (
        output addr_read_bus_data, addr_read_bus_valid, input  addr_read_bus_ready,
        output addr_write_bus_data, addr_write_bus_valid, input  addr_write_bus_ready,
        output data_write_bus_data, data_write_bus_valid, input  data_write_bus_ready,
        input  data_read_bus_data, data_read_bus_valid, output data_read_bus_ready,
        input  resp_write_bus_data, resp_write_bus_valid, output resp_write_bus_ready
    );

    modport slave (
        input  addr_read_bus_data, addr_read_bus_valid, output addr_read_bus_ready,
        input  addr_write_bus_data, addr_write_bus_valid, output addr_write_bus_ready,
        input  data_write_bus_data, data_write_bus_valid, output data_write_bus_ready,
        output data_read_bus_data, data_read_bus_valid, input  data_read_bus_ready,
        output resp_write_bus_data, resp_write_bus_valid, input  resp_write_bus_ready
    );
endinterface

// File: rtl/composite_bus_slice.sv
// Composite bus slice: five independent valid/ready channels between side_a
// (initiator) and side_b (target). Each channel is either a two-entry skid
// buffer or a plain wire, chosen per channel by REG_MASK.

// One channel: skid buffer when REG_EN=1, combinational bypass otherwise.
module composite_bus_slice_chan #(
    parameter int DATA_WIDTH = 8,
    parameter bit REG_EN     = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready
);
    // EMPTY: nothing held; ONE: main register valid; FULL: main + skid valid.
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    generate
        if (REG_EN) begin : g_reg
            state_t                r_state;
            state_t                w_state_nxt;
            logic [DATA_WIDTH-1:0] r_m_data;
            logic [DATA_WIDTH-1:0] r_s_data;
            logic                  w_in_beat;
            logic                  w_out_beat;
            logic                  w_m_ld;
            logic                  w_m_from_s;
            logic                  w_s_ld;

            // in_ready comes only from state, so out_ready never reaches it combinationally.
            assign w_in_beat  = i_in_valid && (r_state != FULL);
            assign w_out_beat = i_out_ready && (r_state != EMPTY);

            // Next state and register load selects for the skid buffer.
            always_comb begin
                w_state_nxt = r_state;
                w_m_ld      = 1'b0;
                w_m_from_s  = 1'b0;
                w_s_ld      = 1'b0;
                case (r_state)
                    EMPTY: begin
                        if (w_in_beat) begin
                            w_state_nxt = ONE;
                            w_m_ld      = 1'b1;
                        end
                    end
                    ONE: begin
                        if (w_in_beat && w_out_beat) begin
                            w_m_ld = 1'b1;
                        end else if (w_in_beat) begin
                            w_state_nxt = FULL;
                            w_s_ld      = 1'b1;
                        end else if (w_out_beat) begin
                            w_state_nxt = EMPTY;
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so only the drain can happen.
                        if (w_out_beat) begin
                            w_state_nxt = ONE;
                            w_m_ld      = 1'b1;
                            w_m_from_s  = 1'b1;
                        end
                    end
                    default: w_state_nxt = EMPTY;
                endcase
            end

            // State register; reset discards anything in flight.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) r_state <= EMPTY;
                else          r_state <= w_state_nxt;
            end

            // Main and skid data registers. They are cleared so that out_data reads 0 in reset.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_m_data <= '0;
                    r_s_data <= '0;
                end else begin
                    if (w_m_ld) r_m_data <= w_m_from_s ? r_s_data : i_in_data;
                    if (w_s_ld) r_s_data <= i_in_data;
                end
            end

            assign o_out_valid = (r_state != EMPTY);
            assign o_out_data  = r_m_data;
            assign o_in_ready  = (r_state != FULL);
        end else begin : g_byp
            // A pure wire: clock and reset are not needed here.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = i_clk ^ i_rst_n;

            assign o_out_data  = i_in_data;
            assign o_out_valid = i_in_valid;
            assign o_in_ready  = i_out_ready;
        end
    endgenerate
endmodule

module composite_bus_slice #(
    parameter int         DATA_WIDTH = 8,
    parameter logic [4:0] REG_MASK   = 5'b11111
) (
    input  logic                    clk,
    input  logic                    rst,
    composite_bus_slice_if.slave    side_a,
    composite_bus_slice_if.master   side_b
);
    // Forward channels: side_a -> side_b.
    composite_bus_slice_chan #(.DATA_WIDTH(DATA_WIDTH), .REG_EN(REG_MASK[0])) u_addr_read (
        .i_clk(clk), .i_rst_n(rst),
        .i_in_data(side_a.addr_read_bus_data), .i_in_valid(side_a.addr_read_bus_valid),
        .o_in_ready(side_a.addr_read_bus_ready),
        .o_out_data(side_b.addr_read_bus_data), .o_out_valid(side_b.addr_read_bus_valid),
        .i_out_ready(side_b.addr_read_bus_ready));

    composite_bus_slice_chan #(.DATA_WIDTH(DATA_WIDTH), .REG_EN(REG_MASK[1])) u_addr_write (
        .i_clk(clk), .i_rst_n(rst),
        .i_in_data(side_a.addr_write_bus_data), .i_in_valid(side_a.addr_write_bus_valid),
        .o_in_ready(side_a.addr_write_bus_ready),
        .o_out_data(side_b.addr_write_bus_data), .o_out_valid(side_b.addr_write_bus_valid),
        .i_out_ready(side_b.addr_write_bus_ready));

    composite_bus_slice_chan #(.DATA_WIDTH(DATA_WIDTH), .REG_EN(REG_MASK[3])) u_data_write (
        .i_clk(clk), .i_rst_n(rst),
        .i_in_data(side_a.data_write_bus_data), .i_in_valid(side_a.data_write_bus_valid),
        .o_in_ready(side_a.data_write_bus_ready),
        .o_out_data(side_b.data_write_bus_data), .o_out_valid(side_b.data_write_bus_valid),
        .i_out_ready(side_b.data_write_bus_ready));

    // Reverse channels: side_b -> side_a.
    composite_bus_slice_chan #(.DATA_WIDTH(DATA_WIDTH), .REG_EN(REG_MASK[2])) u_data_read (
        .i_clk(clk), .i_rst_n(rst),
        .i_in_data(side_b.data_read_bus_data), .i_in_valid(side_b.data_read_bus_valid),
        .o_in_ready(side_b.data_read_bus_ready),
        .o_out_data(side_a.data_read_bus_data), .o_out_valid(side_a.data_read_bus_valid),
        .i_out_ready(side_a.data_read_bus_ready));

    composite_bus_slice_chan #(.DATA_WIDTH(DATA_WIDTH), .REG_EN(REG_MASK[4])) u_resp_write (
        .i_clk(clk), .i_rst_n(rst),
        .i_in_data(side_b.resp_write_bus_data), .i_in_valid(side_b.resp_write_bus_valid),
        .o_in_ready(side_b.resp_write_bus_ready),
        .o_out_data(side_a.resp_write_bus_data), .o_out_valid(side_a.resp_write_bus_valid),
        .i_out_ready(side_a.resp_write_bus_ready));
endmodule

// File: tb/tb_composite_bus_slice.sv
// Bench for composite_bus_slice. Two instances share one stimulus: a fully
// registered slice and a mostly-bypass slice (only addr_write registered).
// Channel index: 0 addr_read, 1 addr_write, 2 data_read, 3 data_write, 4 resp_write.
module tb_composite_bus_slice;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Producer-side stimulus, shared by both instances.
    logic [4:0]      in_valid  = '0;
    logic [4:0][7:0] in_data   = '0;
    logic [4:0]      out_ready = '1;

    // Observed outputs. The _r suffix marks the registered DUT and the _b suffix marks the bypass DUT.
    wire  [4:0]      ovr, irr, ovb, irb;
    wire  [4:0][7:0] odr, odb;

    composite_bus_slice_if #(.DATA_WIDTH(8)) a_r ();
    composite_bus_slice_if #(.DATA_WIDTH(8)) b_r ();
    composite_bus_slice_if #(.DATA_WIDTH(8)) a_b ();
    composite_bus_slice_if #(.DATA_WIDTH(8)) b_b ();

    composite_bus_slice #(.DATA_WIDTH(8), .REG_MASK(5'b11111)) dut_r (
        .clk(clk), .rst(rst), .side_a(a_r), .side_b(b_r));
    composite_bus_slice #(.DATA_WIDTH(8), .REG_MASK(5'b00010)) dut_b (
        .clk(clk), .rst(rst), .side_a(a_b), .side_b(b_b));

    // Wiring for the registered DUT.
    assign a_r.addr_read_bus_data  = in_data[0]; assign a_r.addr_read_bus_valid  = in_valid[0];
    assign irr[0] = a_r.addr_read_bus_ready;     assign b_r.addr_read_bus_ready  = out_ready[0];
    assign odr[0] = b_r.addr_read_bus_data;      assign ovr[0] = b_r.addr_read_bus_valid;
    assign a_r.addr_write_bus_data = in_data[1]; assign a_r.addr_write_bus_valid = in_valid[1];
    assign irr[1] = a_r.addr_write_bus_ready;    assign b_r.addr_write_bus_ready = out_ready[1];
    assign odr[1] = b_r.addr_write_bus_data;     assign ovr[1] = b_r.addr_write_bus_valid;
    assign b_r.data_read_bus_data  = in_data[2]; assign b_r.data_read_bus_valid  = in_valid[2];
    assign irr[2] = b_r.data_read_bus_ready;     assign a_r.data_read_bus_ready  = out_ready[2];
    assign odr[2] = a_r.data_read_bus_data;      assign ovr[2] = a_r.data_read_bus_valid;
    assign a_r.data_write_bus_data = in_data[3]; assign a_r.data_write_bus_valid = in_valid[3];
    assign irr[3] = a_r.data_write_bus_ready;    assign b_r.data_write_bus_ready = out_ready[3];
    assign odr[3] = b_r.data_write_bus_data;     assign ovr[3] = b_r.data_write_bus_valid;
    assign b_r.resp_write_bus_data = in_data[4]; assign b_r.resp_write_bus_valid = in_valid[4];
    assign irr[4] = b_r.resp_write_bus_ready;    assign a_r.resp_write_bus_ready = out_ready[4];
    assign odr[4] = a_r.resp_write_bus_data;     assign ovr[4] = a_r.resp_write_bus_valid;

    // Wiring for the bypass DUT.
    assign a_b.addr_read_bus_data  = in_data[0]; assign a_b.addr_read_bus_valid  = in_valid[0];
    assign irb[0] = a_b.addr_read_bus_ready;     assign b_b.addr_read_bus_ready  = out_ready[0];
    assign odb[0] = b_b.addr_read_bus_data;      assign ovb[0] = b_b.addr_read_bus_valid;
    assign a_b.addr_write_bus_data = in_data[1]; assign a_b.addr_write_bus_valid = in_valid[1];
    assign irb[1] = a_b.addr_write_bus_ready;    assign b_b.addr_write_bus_ready = out_ready[1];
    assign odb[1] = b_b.addr_write_bus_data;     assign ovb[1] = b_b.addr_write_bus_valid;
    assign b_b.data_read_bus_data  = in_data[2]; assign b_b.data_read_bus_valid  = in_valid[2];
    assign irb[2] = b_b.data_read_bus_ready;     assign a_b.data_read_bus_ready  = out_ready[2];
    assign odb[2] = a_b.data_read_bus_data;      assign ovb[2] = a_b.data_read_bus_valid;
    assign a_b.data_write_bus_data = in_data[3]; assign a_b.data_write_bus_valid = in_valid[3];
    assign irb[3] = a_b.data_write_bus_ready;    assign b_b.data_write_bus_ready = out_ready[3];
    assign odb[3] = b_b.data_write_bus_data;     assign ovb[3] = b_b.data_write_bus_valid;
    assign b_b.resp_write_bus_data = in_data[4]; assign b_b.resp_write_bus_valid = in_valid[4];
    assign irb[4] = b_b.resp_write_bus_ready;    assign a_b.resp_write_bus_ready = out_ready[4];
    assign odb[4] = a_b.resp_write_bus_data;     assign ovb[4] = a_b.resp_write_bus_valid;

    int tests = 0;
    int fails = 0;

    // Reference model: each registered channel is a depth-2 FIFO.
    logic [7:0] fifo [5][2];
    int         cnt  [5];

    // Per-channel source: beats queued to send, and an index of the next beat.
    logic [7:0] src_mem [5][1024];
    int         src_n   [5];
    int         src_i   [5];
    bit         shown   [5];
    int         vld_pct = 100;

    task automatic chk(input string tag, input int ch, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s ch%0d t=%0t observed=%h expected=%h", tag, ch, $time, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic [7:0] v);
        src_mem[ch][src_n[ch]] = v;
        src_n[ch]++;
    endtask

    // Present beats at the negedge. Once valid is shown, it is held until the beat is accepted.
    task automatic drive();
        for (int ch = 0; ch < 5; ch++) begin
            if (!shown[ch] && src_i[ch] < src_n[ch] && $urandom_range(0, 99) < vld_pct)
                shown[ch] = 1'b1;
            in_valid[ch] = shown[ch];
            in_data[ch]  = shown[ch] ? src_mem[ch][src_i[ch]] : 8'($urandom);
        end
    endtask

    task automatic chk_reg(input string pfx, input int ch, input logic v, input logic r, input logic [7:0] d);
        chk({pfx, "_vld"}, ch, 8'(v), 8'(cnt[ch] > 0));
        chk({pfx, "_rdy"}, ch, 8'(r), 8'(cnt[ch] < 2));
        if (cnt[ch] > 0)  chk({pfx, "_dat"}, ch, d, fifo[ch][0]);
        else if (!rst)    chk({pfx, "_rstdat"}, ch, d, 8'h00);
    endtask

    // Compare both DUTs against the model. Reset empties every FIFO.
    task automatic check_model();
        if (!rst) for (int ch = 0; ch < 5; ch++) cnt[ch] = 0;
        for (int ch = 0; ch < 5; ch++) chk_reg("reg", ch, ovr[ch], irr[ch], odr[ch]);
        chk_reg("bmask_reg", 1, ovb[1], irb[1], odb[1]);
        for (int ch = 0; ch < 5; ch++) begin
            if (ch != 1) begin
                chk("byp_vld", ch, 8'(ovb[ch]), 8'(in_valid[ch]));
                chk("byp_dat", ch, odb[ch], in_data[ch]);
                chk("byp_rdy", ch, 8'(irb[ch]), 8'(out_ready[ch]));
            end
        end
    endtask

    // Apply the transfers of the coming edge to the model, then step one cycle.
    task automatic commit();
        for (int ch = 0; ch < 5; ch++) begin
            if (rst) begin
                bit ib, ob;
                ib = in_valid[ch] && (cnt[ch] < 2);
                ob = out_ready[ch] && (cnt[ch] > 0);
                if (ob) begin fifo[ch][0] = fifo[ch][1]; cnt[ch]--; end
                if (ib) begin
                    fifo[ch][cnt[ch]] = in_data[ch];
                    cnt[ch]++;
                    src_i[ch]++;
                    shown[ch] = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc();
        drive(); #1; check_model(); commit();
    endtask

    initial begin
        for (int ch = 0; ch < 5; ch++) begin
            cnt[ch] = 0; src_n[ch] = 0; src_i[ch] = 0; shown[ch] = 1'b0;
        end
        @(negedge clk);

        // Reset state, held and then released.
        repeat (2) cyc();
        rst = 1'b1;
        repeat (2) begin
            drive(); #1; check_model();
            for (int ch = 0; ch < 5; ch++) chk("rel_dat", ch, odr[ch], 8'h00);
            commit();
        end

        // Streaming 0x01..0x10 on addr_write with the target always ready.
        for (int v = 1; v <= 16; v++) push(1, 8'(v));
        for (int k = 0; k < 18; k++) begin
            drive(); #1; check_model();
            if (k >= 1 && k <= 16) begin
                chk("strm_vld", 1, 8'(ovr[1]), 8'h01);
                chk("strm_dat", 1, odr[1], 8'(k));
                chk("strm_bdat", 1, odb[1], 8'(k));
                chk("strm_rdy", 1, 8'(irr[1]), 8'h01);
            end
            commit();
        end

        // Backpressure on data_write: A0 and A1 are absorbed, and A2 waits.
        push(3, 8'hA0); push(3, 8'hA1); push(3, 8'hA2);
        for (int k = 0; k < 8; k++) begin
            out_ready[3] = (k >= 4);
            drive(); #1; check_model();
            case (k)
                2, 3: begin
                    chk("bp_rdy", 3, 8'(irr[3]), 8'h00);
                    chk("bp_hold", 3, odr[3], 8'hA0);
                end
                4: chk("bp_o0", 3, odr[3], 8'hA0);
                5: chk("bp_o1", 3, odr[3], 8'hA1);
                6: chk("bp_o2", 3, odr[3], 8'hA2);
                7: chk("bp_done", 3, 8'(ovr[3]), 8'h00);
                default: ;
            endcase
            commit();
        end

        // Reverse data_read: the initiator stalls the second beat for one cycle.
        push(2, 8'h5A); push(2, 8'h5B);
        for (int k = 0; k < 5; k++) begin
            out_ready[2] = (k != 2);
            drive(); #1; check_model();
            case (k)
                1: chk("rev_o0", 2, odr[2], 8'h5A);
                2: chk("rev_stall", 2, odr[2], 8'h5B);
                3: chk("rev_o1", 2, odr[2], 8'h5B);
                4: chk("rev_done", 2, 8'(ovr[2]), 8'h00);
                default: ;
            endcase
            commit();
        end

        // Bypass addr_read: same-cycle data, valid and mirrored ready.
        push(0, 8'h3C); push(0, 8'h3D);
        for (int k = 0; k < 5; k++) begin
            out_ready[0] = (k != 1);
            drive(); #1; check_model();
            if (k == 0) begin
                chk("byp_3c_dat", 0, odb[0], 8'h3C);
                chk("byp_3c_vld", 0, 8'(ovb[0]), 8'h01);
            end
            if (k == 1) chk("byp_rdy_lo", 0, 8'(irb[0]), 8'h00);
            commit();
        end

        // Reset while resp_write is FULL; afterwards only the new beat appears.
        out_ready[4] = 1'b0;
        push(4, 8'h11); push(4, 8'h22);
        repeat (2) cyc();
        drive(); #1; check_model();
        chk("full_rdy", 4, 8'(irr[4]), 8'h00);
        commit();
        rst = 1'b0;
        drive(); #1; check_model();
        chk("mrst_vld", 4, 8'(ovr[4]), 8'h00);
        chk("mrst_rdy", 4, 8'(irr[4]), 8'h01);
        chk("mrst_dat", 4, odr[4], 8'h00);
        commit();
        rst = 1'b1;
        out_ready[4] = 1'b1;
        push(4, 8'h33);
        for (int k = 0; k < 3; k++) begin
            drive(); #1; check_model();
            if (k == 1) chk("post_rst_dat", 4, odr[4], 8'h33);
            if (k == 2) chk("post_rst_end", 4, 8'(ovr[4]), 8'h00);
            commit();
        end

        // Random traffic on every channel, with random stalls and one reset pulse.
        vld_pct = 60;
        for (int n = 0; n < 400; n++) begin
            for (int ch = 0; ch < 5; ch++) begin
                if (src_n[ch] - src_i[ch] < 3 && src_n[ch] < 1020) push(ch, 8'($urandom));
                out_ready[ch] = ($urandom_range(0, 99) < 65);
            end
            rst = (n != 200);
            cyc();
        end
        rst = 1'b1;

        // Drain everything still queued.
        vld_pct = 100;
        out_ready = '1;
        repeat (12) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/composite_bus_slice.md
Name: composite_bus_slice

Overview:
- Parametrised successor to the five-channel composite read/write bus pass-through.
- Carries all five valid/ready channels between side_a (initiator) and side_b (target): addr_read, addr_write, data_write (forward, A->B) and data_read, resp_write (reverse, B->A).
- Each channel is either a registered two-entry skid buffer or a combinational wire, selected per channel by parameter.
- Inserted on long composite-bus paths to break valid, ready and data timing arcs without losing throughput.

Parameters:
- DATA_WIDTH, 8: payload width of every channel.
- REG_MASK, 5'b11111: per-channel register enable. Bit 0 addr_read, bit 1 addr_write, bit 2 data_read, bit 3 data_write, bit 4 resp_write. 1 = skid buffer, 0 = combinational bypass.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- side_a_addr_read_bus_{data,valid,ready}  in,in,out  DATA_WIDTH,1,1  read-address channel from initiator.
- side_a_addr_write_bus_{data,valid,ready}  in,in,out  DATA_WIDTH,1,1  write-address channel from initiator.
- side_a_data_write_bus_{data,valid,ready}  in,in,out  DATA_WIDTH,1,1  write-data channel from initiator.
- side_a_data_read_bus_{data,valid,ready}  out,out,in  DATA_WIDTH,1,1  read-data channel to initiator.
- side_a_resp_write_bus_{data,valid,ready}  out,out,in  DATA_WIDTH,1,1  write-response channel to initiator.
- side_b_addr_read_bus_{data,valid,ready}  out,out,in  DATA_WIDTH,1,1  read-address channel to target.
- side_b_addr_write_bus_{data,valid,ready}  out,out,in  DATA_WIDTH,1,1  write-address channel to target.
- side_b_data_write_bus_{data,valid,ready}  out,out,in  DATA_WIDTH,1,1  write-data channel to target.
- side_b_data_read_bus_{data,valid,ready}  in,in,out  DATA_WIDTH,1,1  read-data channel from target.
- side_b_resp_write_bus_{data,valid,ready}  in,in,out  DATA_WIDTH,1,1  write-response channel from target.

Behaviour:
- Transfer rule: a beat transfers on a rising edge where valid && ready.
- Producer rules: valid must not drop, and data must not change, while valid && !ready. The block obeys this on every output side and relies on it on every input side.
- Channels are fully independent. There is no cross-channel ordering or transaction tracking.
- Bypass channel (mask bit 0): out_data = in_data, out_valid = in_valid, in_ready = out_ready. Purely combinational, no state, unaffected by rst.
- Registered channel (mask bit 1): per-channel skid buffer with main register (m_valid, m_data) and skid register (s_valid, s_data).
  - States: EMPTY (m=0, s=0), ONE (m=1, s=0), FULL (m=1, s=1).
  - out_valid = m_valid; out_data = m_data; in_ready = !s_valid (registered, no combinational path from out_ready).
  - EMPTY + in beat -> ONE; m loads in_data.
  - ONE + in beat + out beat -> ONE; m loads in_data.
  - ONE + in beat, no out beat -> FULL; s loads in_data.
  - ONE + out beat only -> EMPTY.
  - FULL + out beat -> ONE; m loads s_data. No in beat is possible since in_ready=0.
  - FULL, no out beat -> hold.
- Latency: 1 cycle from input transfer to out_valid on an empty buffer.
- Throughput: 1 beat/cycle sustained; no bubbles under continuous ready.
- Ordering: strict FIFO order per channel. No beat is dropped or duplicated.
- Backpressure: in_ready falls on the cycle after the first stalled beat is accepted; exactly one extra beat is absorbed in the skid register.
- Reset (rst=0, asynchronous): all m_valid and s_valid clear. Every registered out_valid = 0, out_data = 0, in_ready = 1 (EMPTY).
- Reset mid-transfer: in-flight beats are discarded; no output glitches to valid=1 during reset. After rst rises, the first accepted beat is the first one emitted.
- Width: data is passed verbatim, with no resizing. DATA_WIDTH >= 1.

Test Plan:
- Reset values: all mask bits 1, hold rst=0 -> every registered *_valid=0, *_data=0, every input-facing *_ready=1. Release rst -> all unchanged until a beat arrives.
- Streaming: side_a_addr_write sends 0x01..0x10 back-to-back with side_b ready=1 -> side_b sees 0x01..0x10 on 16 consecutive cycles, first beat 1 cycle after first acceptance, side_a ready stays 1.
- Backpressure: side_b_data_write_bus_ready=0 while side_a streams 0xA0,0xA1,0xA2.
  - Expect 0xA0 and 0xA1 accepted, side_a ready=0 from the next cycle, side_b data held at 0xA0.
  - Raise ready -> side_b sees 0xA0,0xA1,0xA2 in order, no duplicates.
- Reverse channels: side_b_data_read drives 0x5A, 0x5B while side_a_data_read_bus_ready toggles 1,0,1 -> side_a receives 0x5A, 0x5B in order, data stable during the stall cycle.
- Bypass: REG_MASK=5'b00010 -> addr_read, data_read, data_write and resp_write outputs follow inputs in the same cycle (0x3C in -> 0x3C out, ready mirrored combinationally). addr_write remains 1-cycle registered.
- Reset mid-operation: fill the resp_write buffer to FULL (0x11, 0x22), assert rst for 1 cycle -> side_a_resp_write_bus_valid=0 immediately and side_b_resp_write_bus_ready=1. Then send 0x33 -> side_a sees only 0x33.
